// File: rtl/sramlike_arbiter.sv
// sramlike_arbiter: shares one sram-like master port between the inst and data requesters.
// Data wins by default; a starvation counter forces an inst grant after STARVE_LIMIT contested data grants.
module sramlike_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  output logic        busy,
  output logic        owner
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;
  logic              owner_nxt, m_req_nxt, m_wr_nxt, grant_data;
  logic [1:0]        m_size_nxt;
  logic [31:0]       m_addr_nxt, m_wdata_nxt;
  logic              addr_fire, done_fire;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      starve_cnt <= '0;
      owner      <= 1'b0;
      m_req      <= 1'b0;
      m_wr       <= 1'b0;
      m_size     <= 2'd0;
      m_addr     <= 32'd0;
      m_wdata    <= 32'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      owner      <= owner_nxt;
      m_req      <= m_req_nxt;
      m_wr       <= m_wr_nxt;
      m_size     <= m_size_nxt;
      m_addr     <= m_addr_nxt;
      m_wdata    <= m_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    owner_nxt      = owner;
    m_req_nxt      = m_req;
    m_wr_nxt       = m_wr;
    m_size_nxt     = m_size;
    m_addr_nxt     = m_addr;
    m_wdata_nxt    = m_wdata;
    grant_data     = 1'b0;
    case (state)
      IDLE: begin
        if (inst_req || data_req) begin
          // Counter only advances on contested grants, so it tops out at LIMIT_C.
          grant_data = data_req && (!inst_req || (starve_cnt < LIMIT_C));
          if (inst_req && data_req)
            starve_cnt_nxt = grant_data ? starve_cnt + 1'b1 : '0;
          else
            starve_cnt_nxt = '0;
          owner_nxt   = grant_data;
          m_req_nxt   = 1'b1;
          m_wr_nxt    = grant_data ? data_wr    : inst_wr;
          m_size_nxt  = grant_data ? data_size  : inst_size;
          m_addr_nxt  = grant_data ? data_addr  : inst_addr;
          m_wdata_nxt = grant_data ? data_wdata : inst_wdata;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        if (m_addr_ok) begin
          m_req_nxt = 1'b0;
          state_nxt = m_data_ok ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (m_data_ok)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake pulses are steered to whichever side owns the transaction in flight.
  assign addr_fire    = (state == REQ) && m_addr_ok;
  assign done_fire    = (addr_fire && m_data_ok) || ((state == WAIT) && m_data_ok);
  assign inst_addr_ok = addr_fire && !owner;
  assign data_addr_ok = addr_fire && owner;
  assign inst_data_ok = done_fire && !owner;
  assign data_data_ok = done_fire && owner;
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_sramlike_arbiter.sv
// tb_sramlike_arbiter: randomized requesters and slave checked against a transaction-level model,
// plus directed starvation and reset-in-flight scenarios.
module tb_sramlike_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_addr_ok, m_data_ok, busy, owner;

  sramlike_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;
  int mode        = 0;

  // Transaction-level model: is a transaction open, has its address been accepted, who owns it.
  bit          mdl_busy, mdl_acc, mdl_owner, just_granted, drop_inst, drop_data;
  int          mdl_streak;
  logic        mdl_wr;
  logic [1:0]  mdl_size;
  logic [31:0] mdl_addr, mdl_wdata;
  bit          grant_log[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected)
      pass_count++;
    else
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  task automatic modelReset();
    mdl_busy = 0; mdl_acc = 0; mdl_owner = 0; mdl_streak = 0;
    mdl_wr = 1'b0; mdl_size = 2'd0; mdl_addr = 32'd0; mdl_wdata = 32'd0;
    just_granted = 0; drop_inst = 0; drop_data = 0;
  endtask

  task automatic updateModel();
    bit addr_hit, win_data;
    addr_hit     = mdl_busy && !mdl_acc && m_addr_ok;
    drop_inst    = addr_hit && !mdl_owner;
    drop_data    = addr_hit && mdl_owner;
    just_granted = 0;
    if (!mdl_busy) begin
      if (inst_req || data_req) begin
        if (inst_req && data_req) begin
          win_data   = (mdl_streak < STARVE_LIMIT);
          mdl_streak = win_data ? mdl_streak + 1 : 0;
        end else begin
          win_data   = data_req;
          mdl_streak = 0;
        end
        mdl_owner    = win_data;
        mdl_wr       = win_data ? data_wr    : inst_wr;
        mdl_size     = win_data ? data_size  : inst_size;
        mdl_addr     = win_data ? data_addr  : inst_addr;
        mdl_wdata    = win_data ? data_wdata : inst_wdata;
        mdl_busy     = 1;
        mdl_acc      = 0;
        just_granted = 1;
      end
    end else if (!mdl_acc) begin
      if (m_addr_ok) begin
        if (m_data_ok) mdl_busy = 0;
        else           mdl_acc  = 1;
      end
    end else if (m_data_ok) begin
      mdl_busy = 0;
    end
  endtask

  task automatic applyStimulus();
    bit inst_was_low, data_was_low;
    inst_was_low = !inst_req;
    data_was_low = !data_req;
    if (drop_inst && mode != 1) inst_req = 0;
    if (drop_data && mode != 1) data_req = 0;
    drop_inst = 0;
    drop_data = 0;
    case (mode)
      0: begin
        if (inst_was_low && $urandom_range(0, 2) == 0) begin
          inst_req = 1; inst_wr = 1'($urandom_range(0, 1)); inst_size = 2'($urandom_range(0, 2));
          inst_addr = $urandom; inst_wdata = $urandom;
        end
        if (data_was_low && $urandom_range(0, 2) == 0) begin
          data_req = 1; data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
          data_addr = $urandom; data_wdata = $urandom;
        end
        m_addr_ok = ($urandom_range(0, 2) != 0);
        m_data_ok = ($urandom_range(0, 2) == 0);
      end
      1: begin
        inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1;
      end
      2: begin
        inst_req = 0; m_addr_ok = 1; m_data_ok = 0;
      end
      default: begin
        inst_req = 0; data_req = 0; m_addr_ok = 1; m_data_ok = 1;
      end
    endcase
    m_rdata = $urandom;
  endtask

  task automatic checkCycle();
    bit exp_addr_ok, exp_done;
    exp_addr_ok = mdl_busy && !mdl_acc && m_addr_ok;
    exp_done    = mdl_busy && (mdl_acc || m_addr_ok) && m_data_ok;
    checkOutput("m_req",        32'(m_req),        32'(mdl_busy && !mdl_acc));
    checkOutput("busy",         32'(busy),         32'(mdl_busy));
    checkOutput("owner",        32'(owner),        32'(mdl_owner));
    checkOutput("m_wr",         32'(m_wr),         32'(mdl_wr));
    checkOutput("m_size",       32'(m_size),       32'(mdl_size));
    checkOutput("m_addr",       m_addr,            mdl_addr);
    checkOutput("m_wdata",      m_wdata,           mdl_wdata);
    checkOutput("inst_addr_ok", 32'(inst_addr_ok), 32'(exp_addr_ok && !mdl_owner));
    checkOutput("data_addr_ok", 32'(data_addr_ok), 32'(exp_addr_ok && mdl_owner));
    checkOutput("inst_data_ok", 32'(inst_data_ok), 32'(exp_done && !mdl_owner));
    checkOutput("data_data_ok", 32'(data_data_ok), 32'(exp_done && mdl_owner));
    if (exp_done)
      checkOutput("rdata", mdl_owner ? data_rdata : inst_rdata, m_rdata);
    if (mode == 1 && just_granted)
      grant_log.push_back(owner);
  endtask

  task automatic runCycle();
    applyStimulus();
    @(negedge clk);
    checkCycle();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  initial begin
    string pattern;
    int    bound;
    resetn = 0;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    m_rdata = 0; m_addr_ok = 0; m_data_ok = 0;
    modelReset();

    // Reset held with requests and slave handshakes toggling: everything stays quiet.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      inst_req = 1'($urandom_range(0, 1)); data_req = 1'($urandom_range(0, 1));
      m_addr_ok = 1; m_data_ok = 1;
      @(negedge clk);
      checkCycle();
    end
    inst_req = 0; data_req = 0;
    resetn = 1;
    @(posedge clk); updateModel(); #1;

    // Both requesters held continuously with a 1-cycle slave.
    mode = 1;
    inst_addr = 32'hBFC00000; inst_wr = 0; inst_size = 2;
    data_addr = 32'h80000010; data_wr = 1; data_size = 2; data_wdata = 32'hDEADBEEF;
    bound = 0;
    while (grant_log.size() < 10 && bound < 100) begin
      runCycle();
      bound++;
    end
    checkOutput("starve_grants", 32'(grant_log.size()), 32'd10);
    pattern = "DDDDIDDDDI";
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      checkOutput($sformatf("grant_order[%0d]", i), 32'(grant_log[i]), 32'(pattern[i] == "D"));

    // Drain, then park a data write in WAIT and hit it with reset.
    mode = 3;
    repeat (3) runCycle();
    mode = 2;
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h80000010; data_wdata = 32'hDEADBEEF;
    bound = 0;
    while (!(mdl_busy && mdl_acc && mdl_owner) && bound < 20) begin
      runCycle();
      bound++;
    end
    checkOutput("reach_wait", 32'(mdl_busy && mdl_acc && mdl_owner), 32'd1);
    #2;
    resetn = 0; m_data_ok = 1; data_req = 0;
    inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC00040; inst_wdata = $urandom;
    #1;
    checkOutput("rst_m_req",        32'(m_req),        32'd0);
    checkOutput("rst_busy",         32'(busy),         32'd0);
    checkOutput("rst_data_data_ok", 32'(data_data_ok), 32'd0);
    checkOutput("rst_owner",        32'(owner),        32'd0);
    modelReset();
    @(negedge clk);
    resetn = 1; m_data_ok = 0; m_addr_ok = 0;
    @(posedge clk); updateModel(); #1;
    checkOutput("post_rst_grant_req",  32'(m_req), 32'd1);
    checkOutput("post_rst_grant_addr", m_addr,     32'hBFC00040);

    mode = 0;
    repeat (400) runCycle();

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
